spi_mem_master: RTL and testbench

SPI mode-0 master that executes the CPU's memory requests (instruction fetch, load, store) against two external serial memories: flash on `cs1`, RAM on `cs2`. It sits directly downstream of the CPU core's fetch/load-store state machine, drives the chip pins (`uo_out[3:0]`, `ui_in[0]`) and returns left-aligned read data with a level handshake.

---
 rtl/spi_mem_master.sv | 277 +++++++++++++++++++++++++++
 tb/tb_spi_mem_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_master.sv
// SPI mode-0 master serving CPU fetch/load/store against flash (cs1) and RAM (cs2).
// Define SPI_MEM_FAST_READ_EN to use opcode 0x0B with 8 dummy clocks for flash reads.
module spi_mem_master #(
  parameter int unsigned CLK_DIV   = 1,
  parameter logic [7:0]  READ_CMD  = 8'h03,
  parameter logic [7:0]  WRITE_CMD = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_request,
  input  logic        is_write,
  input  logic [2:0]  num_bytes,
  input  logic [24:0] target_address,
  input  logic [31:0] write_value,
  output logic [31:0] fetched_value,
  output logic        request_done,
  output logic        sclk,
  output logic        mosi,
  output logic        cs1,
  output logic        cs2,
  input  logic        miso
);

  localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);
`ifdef SPI_MEM_FAST_READ_EN
  localparam logic [7:0] FastReadCmd = 8'h0B;
`endif

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCmd   = 3'd1,
    StAddr  = 3'd2,
`ifdef SPI_MEM_FAST_READ_EN
    StDummy = 3'd3,
`endif
    StData  = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic        wr_q, wr_d;
  logic [2:0]  nb_q, nb_d;
  logic [24:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  // Bit sequencer
  logic [15:0] div_q, div_d;
  logic        phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic        tail_q, tail_d;

  // Read capture
  logic [4:0]  rx_idx_q, rx_idx_d;
  logic [31:0] fetched_q, fetched_d;

  // Registered pins
  logic sclk_q, sclk_d;
  logic mosi_q, mosi_d;
  logic cs1_q, cs1_d;
  logic cs2_q, cs2_d;

  logic        accept;
  logic        len_ok;
  logic        shifting;
  logic        bit_end;
  logic        last_bit;
  logic        read_data;
  logic        sample;
  logic [7:0]  opcode;
  logic [31:0] wdata_aligned;
  logic [5:0]  data_bits;
  logic [4:0]  data_last;
`ifdef SPI_MEM_FAST_READ_EN
  logic        fast_rd;
  logic        fast_req;
`endif

  assign accept = (state_q == StIdle) && start_request;
  assign len_ok = (num_bytes != 3'd0) && (num_bytes <= 3'd4);

`ifdef SPI_MEM_FAST_READ_EN
  assign fast_rd  = ~wr_q & ~addr_q[24];
  assign fast_req = ~is_write & ~target_address[24];
  assign opcode   = is_write ? WRITE_CMD : (fast_req ? FastReadCmd : READ_CMD);
  assign shifting = ((state_q == StCmd) || (state_q == StAddr) || (state_q == StDummy) ||
                     (state_q == StData)) && !tail_q;
`else
  assign opcode   = is_write ? WRITE_CMD : READ_CMD;
  assign shifting = ((state_q == StCmd) || (state_q == StAddr) || (state_q == StData)) &&
                    !tail_q;
`endif

  // A bit ends when the high half of sclk has run its full length
  assign bit_end   = shifting && phase_q && (div_q == DivLast);
  assign last_bit  = bit_end && (bit_q == 5'd0);
  assign read_data = (state_q == StData) && !wr_q;
  // sclk_q still low while the next value is high: this edge raises sclk on the pin
  assign sample    = shifting && read_data && phase_q && !sclk_q;

  assign data_bits = {nb_q, 3'b000};
  assign data_last = 5'(data_bits - 6'd1);

  always_comb begin
    unique case (nb_q)
      3'd1:    wdata_aligned = {wdata_q[7:0], 24'h0};
      3'd2:    wdata_aligned = {wdata_q[15:0], 16'h0};
      3'd3:    wdata_aligned = {wdata_q[23:0], 8'h0};
      default: wdata_aligned = wdata_q;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_request) state_d = len_ok ? StCmd : StDone;
      StCmd:   if (last_bit) state_d = StAddr;
`ifdef SPI_MEM_FAST_READ_EN
      StAddr:  if (last_bit) state_d = fast_rd ? StDummy : StData;
      StDummy: if (last_bit) state_d = StData;
`else
      StAddr:  if (last_bit) state_d = StData;
`endif
      // One tail cycle lets the registered pins return to idle before DONE
      StData:  if (tail_q) state_d = StDone;
      StDone:  if (!start_request) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin outputs, registered so they are glitch-free
  always_comb begin
    sclk_d = 1'b0;
    mosi_d = 1'b0;
    cs1_d  = 1'b1;
    cs2_d  = 1'b1;
    if (shifting) begin
      sclk_d = phase_q;
      mosi_d = tx_q[31] & ~read_data;
      cs1_d  = addr_q[24];
      cs2_d  = ~addr_q[24];
    end
  end

  // Datapath next state
  always_comb begin
    wr_d      = wr_q;
    nb_d      = nb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    tail_d    = tail_q;
    rx_idx_d  = rx_idx_q;
    fetched_d = fetched_q;

    if (accept) begin
      wr_d      = is_write;
      nb_d      = num_bytes;
      addr_d    = target_address;
      wdata_d   = write_value;
      div_d     = '0;
      phase_d   = 1'b0;
      bit_d     = 5'd7;
      tx_d      = {opcode, 24'h0};
      tail_d    = 1'b0;
      rx_idx_d  = '0;
      fetched_d = '0;
    end

    if (shifting) begin
      if (div_q == DivLast) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + 16'd1;
      end

      if (bit_end) begin
        tx_d  = {tx_q[30:0], 1'b0};
        bit_d = bit_q - 5'd1;
      end

      if (sample) begin
        fetched_d[5'd31 - rx_idx_q] = miso;
        rx_idx_d = rx_idx_q + 5'd1;
      end

      if (last_bit) begin
        case (state_q)
          StCmd: begin
            tx_d  = {addr_q[23:0], 8'h00};
            bit_d = 5'd23;
          end
          StAddr: begin
`ifdef SPI_MEM_FAST_READ_EN
            if (fast_rd) begin
              tx_d  = '0;
              bit_d = 5'd7;
            end else
`endif
            begin
              tx_d  = wdata_aligned;
              bit_d = data_last;
            end
          end
`ifdef SPI_MEM_FAST_READ_EN
          StDummy: begin
            tx_d  = '0;
            bit_d = data_last;
          end
`endif
          StData:  tail_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      nb_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      div_q     <= '0;
      phase_q   <= 1'b0;
      bit_q     <= '0;
      tx_q      <= '0;
      tail_q    <= 1'b0;
      rx_idx_q  <= '0;
      fetched_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs1_q     <= 1'b1;
      cs2_q     <= 1'b1;
    end else begin
      wr_q      <= wr_d;
      nb_q      <= nb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      tail_q    <= tail_d;
      rx_idx_q  <= rx_idx_d;
      fetched_q <= fetched_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs1_q     <= cs1_d;
      cs2_q     <= cs2_d;
    end
  end

  assign sclk          = sclk_q;
  assign mosi          = mosi_q;
  assign cs1           = cs1_q;
  assign cs2           = cs2_q;
  assign fetched_value = fetched_q;
  assign request_done  = (state_q == StDone) && start_request;

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed self-checking bench for spi_mem_master with a behavioural SPI memory model.
`timescale 1ns/1ps
module tb_spi_mem_master;

`ifdef SPI_MEM_FAST_READ_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_request = 1'b0;
  logic        is_write = 1'b0;
  logic [2:0]  num_bytes = 3'd0;
  logic [24:0] target_address = '0;
  logic [31:0] write_value = '0;
  logic [31:0] fetched_value;
  logic        request_done;
  logic        sclk, mosi, cs1, cs2;
  logic        miso = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_mem_master dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_request  (start_request),
    .is_write       (is_write),
    .num_bytes      (num_bytes),
    .target_address (target_address),
    .write_value    (write_value),
    .fetched_value  (fetched_value),
    .request_done   (request_done),
    .sclk           (sclk),
    .mosi           (mosi),
    .cs1            (cs1),
    .cs2            (cs2),
    .miso           (miso)
  );

  // Memory model: captures mosi on sclk rise, serves resp after hdr header bits
  wire         cs_any = cs1 & cs2;
  int          rise_cnt = 0;
  logic [79:0] cap = '0;
  logic [31:0] resp = '0;
  int          hdr = 32;
  int          cs1_low = 0;
  int          cs2_low = 0;
  int          sclk_hi = 0;

  always @(posedge sclk or negedge cs_any) begin
    if (sclk) begin
      rise_cnt = rise_cnt + 1;
      cap = {cap[78:0], mosi};
    end else begin
      rise_cnt = 0;
      cap = '0;
    end
  end

  always @(negedge sclk) begin
    int k;
    k = rise_cnt - hdr;
    if (k >= 0 && k < 32) miso = resp[5'(31 - k)];
  end

  always @(negedge clk) begin
    if (!cs1) cs1_low = cs1_low + 1;
    if (!cs2) cs2_low = cs2_low + 1;
    if (sclk) sclk_hi = sclk_hi + 1;
  end

  function automatic logic [7:0] cap_byte(input int idx);
    logic [79:0] t;
    t = cap >> (rise_cnt - 8 * (idx + 1));
    return t[7:0];
  endfunction

  // Raises a request and waits (bounded) for request_done; edges = -1 on timeout
  task automatic do_xfer(input bit sync, input logic wr, input logic [2:0] n,
                         input logic [24:0] addr, input logic [31:0] wd,
                         input logic [31:0] rsp, input int h,
                         output int edges, output int cs_edge);
    resp = rsp;
    hdr  = h;
    if (sync) begin
      @(posedge clk);
      #1;
    end
    is_write       = wr;
    num_bytes      = n;
    target_address = addr;
    write_value    = wd;
    start_request  = 1'b1;
    edges   = -1;
    cs_edge = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        is_write       = ~wr;
        num_bytes      = 3'd3;
        target_address = ~addr;
        write_value    = ~wd;
      end
      if (cs_edge < 0 && !cs_any) cs_edge = i;
      if (request_done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic drop_req();
    start_request = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #8;
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b want=0", sclk); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b want=0", mosi); end
    checks++; if (cs1 !== 1'b1) begin failures++; $display("FAIL reset_cs1 got=%b want=1", cs1); end
    checks++; if (cs2 !== 1'b1) begin failures++; $display("FAIL reset_cs2 got=%b want=1", cs2); end
    checks++; if (request_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", request_done); end
    checks++; if (fetched_value !== 32'h0) begin failures++; $display("FAIL reset_fetched got=%h want=0", fetched_value); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    int e, ce, c1, c2, exp_e, exp_low;
    logic [7:0] exp_op;
    exp_e   = Fast ? 146 : 130;
    exp_low = Fast ? 144 : 128;
    exp_op  = Fast ? 8'h0B : 8'h03;
    c1 = cs1_low;
    c2 = cs2_low;
    do_xfer(1'b1, 1'b0, 3'd4, 25'h000100, 32'h0, 32'h13005000, Fast ? 40 : 32, e, ce);
    checks++; if (e != exp_e) begin failures++; $display("FAIL fetch_done_edge got=%0d want=%0d", e, exp_e); end
    checks++; if (ce != 2) begin failures++; $display("FAIL fetch_cs_edge got=%0d want=2", ce); end
    checks++; if (fetched_value !== 32'h13005000) begin failures++; $display("FAIL fetch_data got=%h want=13005000", fetched_value); end
    checks++; if (rise_cnt != exp_low / 2) begin failures++; $display("FAIL fetch_sclk_count got=%0d want=%0d", rise_cnt, exp_low / 2); end
    checks++; if (cs1_low - c1 != exp_low) begin failures++; $display("FAIL fetch_cs1_low got=%0d want=%0d", cs1_low - c1, exp_low); end
    checks++; if (cs2_low - c2 != 0) begin failures++; $display("FAIL fetch_cs2_low got=%0d want=0", cs2_low - c2); end
    checks++; if (cap_byte(0) !== exp_op) begin failures++; $display("FAIL fetch_opcode got=%h want=%h", cap_byte(0), exp_op); end
    checks++; if ({cap_byte(1), cap_byte(2), cap_byte(3)} !== 24'h000100) begin failures++; $display("FAIL fetch_addr got=%h want=000100", {cap_byte(1), cap_byte(2), cap_byte(3)}); end
    checks++; if (cap[39:0] !== 40'h0) begin failures++; $display("FAIL fetch_mosi_idle got=%h want=0", cap[39:0]); end
    drop_req();
  endtask

  task automatic test_store();
    int e, ce, c1, c2;
    c1 = cs1_low;
    c2 = cs2_low;
    do_xfer(1'b1, 1'b1, 3'd1, 25'h1000010, 32'hDEADBEEF, 32'h0, 32, e, ce);
    checks++; if (e != 82) begin failures++; $display("FAIL store_done_edge got=%0d want=82", e); end
    checks++; if (rise_cnt != 40) begin failures++; $display("FAIL store_sclk_count got=%0d want=40", rise_cnt); end
    checks++; if ({cap_byte(0), cap_byte(1), cap_byte(2), cap_byte(3), cap_byte(4)} !== 40'h02000010EF) begin
      failures++; $display("FAIL store_mosi got=%h want=02000010ef", {cap_byte(0), cap_byte(1), cap_byte(2), cap_byte(3), cap_byte(4)}); end
    checks++; if (cs1_low - c1 != 0) begin failures++; $display("FAIL store_cs1_low got=%0d want=0", cs1_low - c1); end
    checks++; if (cs2_low - c2 != 80) begin failures++; $display("FAIL store_cs2_low got=%0d want=80", cs2_low - c2); end
    drop_req();
  endtask

  task automatic test_back_to_back();
    int e, ce;
    do_xfer(1'b1, 1'b0, 3'd2, 25'h1000200, 32'h0, 32'hABCD0000, 32, e, ce);
    checks++; if (e != 98) begin failures++; $display("FAIL half_done_edge got=%0d want=98", e); end
    checks++; if (fetched_value !== 32'hABCD0000) begin failures++; $display("FAIL half_data got=%h want=abcd0000", fetched_value); end
    checks++; if (cap_byte(0) !== 8'h03) begin failures++; $display("FAIL half_opcode got=%h want=03", cap_byte(0)); end
    start_request = 1'b0;
    #1;
    checks++; if (request_done !== 1'b0) begin failures++; $display("FAIL half_done_fall got=%b want=0", request_done); end
    @(posedge clk);
    #1;
    do_xfer(1'b0, 1'b0, 3'd1, 25'h1000300, 32'h0, 32'h77000000, 32, e, ce);
    checks++; if (ce != 2) begin failures++; $display("FAIL b2b_cs_edge got=%0d want=2", ce); end
    checks++; if (e != 82) begin failures++; $display("FAIL b2b_done_edge got=%0d want=82", e); end
    checks++; if (fetched_value !== 32'h77000000) begin failures++; $display("FAIL b2b_data got=%h want=77000000", fetched_value); end
    drop_req();
  endtask

  task automatic test_invalid_len();
    int e, ce, c1, c2, sh;
    c1 = cs1_low;
    c2 = cs2_low;
    sh = sclk_hi;
    do_xfer(1'b1, 1'b0, 3'd0, 25'h0000040, 32'h0, 32'hFFFFFFFF, 32, e, ce);
    checks++; if (e != 1) begin failures++; $display("FAIL inv0_done_edge got=%0d want=1", e); end
    checks++; if (fetched_value !== 32'h0) begin failures++; $display("FAIL inv0_fetched got=%h want=0", fetched_value); end
    drop_req();
    do_xfer(1'b1, 1'b1, 3'd5, 25'h1000040, 32'h1234, 32'h0, 32, e, ce);
    checks++; if (e != 1) begin failures++; $display("FAIL inv5_done_edge got=%0d want=1", e); end
    drop_req();
    checks++; if (ce != -1) begin failures++; $display("FAIL inv_cs_activity got=%0d want=-1", ce); end
    checks++; if (cs1_low + cs2_low - c1 - c2 != 0) begin failures++; $display("FAIL inv_cs_cycles got=%0d want=0", cs1_low + cs2_low - c1 - c2); end
    checks++; if (sclk_hi - sh != 0) begin failures++; $display("FAIL inv_sclk_cycles got=%0d want=0", sclk_hi - sh); end
  endtask

  task automatic test_reset_mid_addr();
    int e, ce;
    bit hit;
    resp = 32'h0;
    @(posedge clk);
    #1;
    is_write = 1'b0; num_bytes = 3'd4; target_address = 25'h0ABCDE; start_request = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rise_cnt >= 12 && sclk) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach_addr got=0 want=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cs1 !== 1'b1) begin failures++; $display("FAIL rstmid_cs1 got=%b want=1", cs1); end
    checks++; if (cs2 !== 1'b1) begin failures++; $display("FAIL rstmid_cs2 got=%b want=1", cs2); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rstmid_sclk got=%b want=0", sclk); end
    start_request = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_xfer(1'b1, 1'b0, 3'd1, 25'h1000400, 32'h0, 32'h5A000000, 32, e, ce);
    checks++; if (e != 82) begin failures++; $display("FAIL rstmid_after_edge got=%0d want=82", e); end
    checks++; if (fetched_value !== 32'h5A000000) begin failures++; $display("FAIL rstmid_after_data got=%h want=5a000000", fetched_value); end
    drop_req();
  endtask

  task automatic test_ram_read_word();
    int e, ce;
    do_xfer(1'b1, 1'b0, 3'd4, 25'h1123456, 32'h0, 32'hC0FFEE11, 32, e, ce);
    checks++; if (e != 130) begin failures++; $display("FAIL ramrd_done_edge got=%0d want=130", e); end
    checks++; if (cap_byte(0) !== 8'h03) begin failures++; $display("FAIL ramrd_opcode got=%h want=03", cap_byte(0)); end
    checks++; if ({cap_byte(1), cap_byte(2), cap_byte(3)} !== 24'h123456) begin failures++; $display("FAIL ramrd_addr got=%h want=123456", {cap_byte(1), cap_byte(2), cap_byte(3)}); end
    checks++; if (fetched_value !== 32'hC0FFEE11) begin failures++; $display("FAIL ramrd_data got=%h want=c0ffee11", fetched_value); end
    drop_req();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_invalid_len();
    test_reset_mid_addr();
    test_ram_read_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
